// File: rtl/min_max_decoder.sv
// Receive-side decoder for the min/max LED bar: captures an osc-off and an osc-on
// snapshot, scans them one bit per cycle and recovers display class and min/value/max.
module min_max_decoder #(
  parameter int VALSIZE = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    snap_valid_i,
  input  logic                    osc_i,
  input  logic [2**VALSIZE-1:0]   leds_i,
  output logic                    busy_o,
  output logic                    valid_o,
  input  logic                    ack_i,
  output logic [1:0]              kind_o,
  output logic [VALSIZE-1:0]      min_o,
  output logic [VALSIZE-1:0]      value_o,
  output logic [VALSIZE-1:0]      max_o
);

  localparam int N  = 2**VALSIZE;
  localparam int CW = VALSIZE + 1;

  localparam logic [1:0] K_EMPTY   = 2'b00;
  localparam logic [1:0] K_FULL    = 2'b01;
  localparam logic [1:0] K_BAR     = 2'b10;
  localparam logic [1:0] K_INVALID = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SCAN, S_RESULT} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [N-1:0]         r_lo;
  logic [N-1:0]         r_hi;
  logic                 r_lo_ok;
  logic                 r_hi_ok;
  logic [CW-1:0]        r_k;

  logic [VALSIZE-1:0]   r_lo_first;
  logic [VALSIZE-1:0]   r_lo_last;
  logic [CW-1:0]        r_lo_cnt;
  logic [VALSIZE-1:0]   r_hi_first;
  logic [VALSIZE-1:0]   r_hi_last;
  logic [CW-1:0]        r_hi_cnt;
  logic                 r_viol;

  logic                 r_valid;
  logic [1:0]           r_kind;
  logic [VALSIZE-1:0]   r_min;
  logic [VALSIZE-1:0]   r_value;
  logic [VALSIZE-1:0]   r_max;

  logic [VALSIZE-1:0]   w_idx;
  logic                 w_lo_bit;
  logic                 w_hi_bit;
  logic                 w_both;
  logic                 w_scan_done;
  logic                 w_is_empty;
  logic                 w_is_full;
  logic                 w_is_bar;

  // Number of positions covered by [first, last]; equals popcount only for a contiguous run.
  function automatic logic [CW-1:0] f_span(input logic [VALSIZE-1:0] first,
                                           input logic [VALSIZE-1:0] last);
    f_span = {1'b0, last} - {1'b0, first} + CW'(1);
  endfunction

  assign w_idx       = r_k[VALSIZE-1:0];
  assign w_scan_done = (r_k == CW'(N));
  assign w_lo_bit    = !w_scan_done && r_lo[w_idx];
  assign w_hi_bit    = !w_scan_done && r_hi[w_idx];
  assign w_both      = (r_lo_ok || (snap_valid_i && !osc_i)) &&
                       (r_hi_ok || (snap_valid_i && osc_i));

  assign w_is_empty = (r_lo_cnt == '0) && (r_hi_cnt == '0);
  assign w_is_full  = (r_lo_cnt == CW'(N)) && (r_hi_cnt == CW'(N));
  assign w_is_bar   = (r_lo_cnt != '0) &&
                      (r_lo_cnt == f_span(r_lo_first, r_lo_last)) &&
                      (r_hi_cnt == f_span(r_hi_first, r_hi_last)) &&
                      !r_viol && (r_lo_first == r_hi_first);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start_i) w_state_nxt = S_CAPTURE;
      S_CAPTURE: if (w_both) w_state_nxt = S_SCAN;
      S_SCAN:    if (w_scan_done) w_state_nxt = S_RESULT;
      S_RESULT:  if (ack_i) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lo       <= '0;
      r_hi       <= '0;
      r_lo_ok    <= 1'b0;
      r_hi_ok    <= 1'b0;
      r_k        <= '0;
      r_lo_first <= '0;
      r_lo_last  <= '0;
      r_lo_cnt   <= '0;
      r_hi_first <= '0;
      r_hi_last  <= '0;
      r_hi_cnt   <= '0;
      r_viol     <= 1'b0;
      r_valid    <= 1'b0;
      r_kind     <= K_EMPTY;
      r_min      <= '0;
      r_value    <= '0;
      r_max      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_lo_ok <= 1'b0;
            r_hi_ok <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (snap_valid_i) begin
            if (osc_i) begin
              r_hi    <= leds_i;
              r_hi_ok <= 1'b1;
            end else begin
              r_lo    <= leds_i;
              r_lo_ok <= 1'b1;
            end
          end
          // Scan trackers are unused while capturing, so keep them primed for SCAN.
          r_k        <= '0;
          r_lo_first <= '0;
          r_lo_last  <= '0;
          r_lo_cnt   <= '0;
          r_hi_first <= '0;
          r_hi_last  <= '0;
          r_hi_cnt   <= '0;
          r_viol     <= 1'b0;
        end
        S_SCAN: begin
          if (!w_scan_done) begin
            if (w_lo_bit) begin
              if (r_lo_cnt == '0) r_lo_first <= w_idx;
              r_lo_last <= w_idx;
              r_lo_cnt  <= r_lo_cnt + CW'(1);
            end
            if (w_hi_bit) begin
              if (r_hi_cnt == '0) r_hi_first <= w_idx;
              r_hi_last <= w_idx;
              r_hi_cnt  <= r_hi_cnt + CW'(1);
            end
            if (w_lo_bit && !w_hi_bit) r_viol <= 1'b1;
            r_k <= r_k + CW'(1);
          end else begin
            r_valid <= 1'b1;
            if (w_is_empty) begin
              r_kind  <= K_EMPTY;
              r_min   <= '0;
              r_value <= '0;
              r_max   <= '0;
            end else if (w_is_full) begin
              r_kind  <= K_FULL;
              r_min   <= '0;
              r_value <= VALSIZE'(N-1);
              r_max   <= VALSIZE'(N-1);
            end else if (w_is_bar) begin
              r_kind  <= K_BAR;
              r_min   <= r_hi_first;
              r_value <= r_lo_last;
              r_max   <= r_hi_last;
            end else begin
              r_kind  <= K_INVALID;
              r_min   <= '0;
              r_value <= '0;
              r_max   <= '0;
            end
          end
        end
        S_RESULT: begin
          if (ack_i) r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (r_state != S_IDLE);
  assign valid_o = r_valid;
  assign kind_o  = r_kind;
  assign min_o   = r_min;
  assign value_o = r_value;
  assign max_o   = r_max;

endmodule

// File: tb/tb_min_max_decoder.sv
// Scoreboard bench for min_max_decoder: drivers push expected results, a negedge
// monitor pops and compares each time valid_o rises.
module tb_min_max_decoder;

  localparam int VALSIZE = 4;
  localparam int N       = 16;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              start_i;
  logic              snap_valid_i;
  logic              osc_i;
  logic [N-1:0]      leds_i;
  logic              busy_o;
  logic              valid_o;
  logic              ack_i;
  logic [1:0]        kind_o;
  logic [VALSIZE-1:0] min_o;
  logic [VALSIZE-1:0] value_o;
  logic [VALSIZE-1:0] max_o;

  always #5 clk = ~clk;

  min_max_decoder #(.VALSIZE(VALSIZE)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .snap_valid_i (snap_valid_i),
    .osc_i        (osc_i),
    .leds_i       (leds_i),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .ack_i        (ack_i),
    .kind_o       (kind_o),
    .min_o        (min_o),
    .value_o      (value_o),
    .max_o        (max_o)
  );

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] mn;
    logic [3:0] vl;
    logic [3:0] mx;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid_o && !prev_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: valid_o rose with nothing expected (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("kind",  {30'd0, kind_o},  {30'd0, e.kind});
        chk("min",   {28'd0, min_o},   {28'd0, e.mn});
        chk("value", {28'd0, value_o}, {28'd0, e.vl});
        chk("max",   {28'd0, max_o},   {28'd0, e.mx});
      end
    end
    prev_valid <= valid_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input logic osc, input logic [N-1:0] v);
    snap_valid_i = 1'b1;
    osc_i        = osc;
    leds_i       = v;
    tick();
    snap_valid_i = 1'b0;
    osc_i        = 1'b0;
    leds_i       = '0;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic wait_result(input int cap, input bit start_noise);
    int n = 0;
    while (!valid_o && n < 60) begin
      start_i = (start_noise && n == 3);
      tick();
      n++;
    end
    start_i = 1'b0;
    chk("valid_timeout", {31'd0, valid_o}, 32'd1);
    chk("latency", cyc - cap, N + 1);
  endtask

  task automatic ack_result();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("valid_after_ack", {31'd0, valid_o}, 32'd0);
    chk("busy_after_ack",  {31'd0, busy_o},  32'd0);
  endtask

  task automatic run(input logic [N-1:0] lo, input logic [N-1:0] hi, input bit hi_first,
                     input logic [1:0] k, input logic [3:0] mn, input logic [3:0] vl,
                     input logic [3:0] mx, input bit start_noise);
    int cap;
    sb.push_back('{kind: k, mn: mn, vl: vl, mx: mx});
    do_start();
    if (hi_first) begin
      snap(1'b1, hi);
      snap(1'b0, lo);
    end else begin
      snap(1'b0, lo);
      snap(1'b1, hi);
    end
    cap = cyc;
    wait_result(cap, start_noise);
    ack_result();
    tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},  {31'd0, busy_o},  32'd0);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_kind"},  {30'd0, kind_o},  32'd0);
    chk({tag, "_min"},   {28'd0, min_o},   32'd0);
    chk({tag, "_value"}, {28'd0, value_o}, 32'd0);
    chk({tag, "_max"},   {28'd0, max_o},   32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cap;
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    snap_valid_i = 1'b0;
    osc_i        = 1'b0;
    leds_i       = '0;
    ack_i        = 1'b0;
    repeat (3) tick();
    chk_zero_outputs("reset");
    rst_ni = 1'b1;
    tick();

    // ack while nothing is pending must not disturb anything
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    chk("ack_idle_valid", {31'd0, valid_o}, 32'd0);
    chk("ack_idle_busy",  {31'd0, busy_o},  32'd0);

    run(16'h01F8, 16'h1FF8, 1'b0, 2'b10, 4'd3, 4'd8, 4'd12, 1'b0);
    run(16'h0000, 16'h0000, 1'b0, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
    run(16'hFFFF, 16'hFFFF, 1'b0, 2'b01, 4'd0, 4'd15, 4'd15, 1'b0);
    run(16'h00FF, 16'h00FF, 1'b0, 2'b10, 4'd0, 4'd7, 4'd7, 1'b0);
    run(16'h0105, 16'h01FF, 1'b0, 2'b11, 4'd0, 4'd0, 4'd0, 1'b0);
    run(16'h0030, 16'h000F, 1'b0, 2'b11, 4'd0, 4'd0, 4'd0, 1'b0);
    run(16'h0007, 16'h003F, 1'b1, 2'b10, 4'd0, 4'd2, 4'd5, 1'b0);

    // repeated lo snapshot: last one wins
    sb.push_back('{kind: 2'b10, mn: 4'd0, vl: 4'd2, mx: 4'd5});
    do_start();
    snap(1'b0, 16'h0003);
    snap(1'b0, 16'h0007);
    chk("still_capturing", {31'd0, busy_o}, 32'd1);
    snap(1'b1, 16'h003F);
    cap = cyc;
    wait_result(cap, 1'b0);
    ack_result();
    tick();

    // reset in the middle of a scan, at index 5
    do_start();
    snap(1'b0, 16'h01F8);
    snap(1'b1, 16'h1FF8);
    repeat (5) tick();
    chk("busy_mid_scan", {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    chk_zero_outputs("midscan_reset");
    tick();
    run(16'h01F8, 16'h1FF8, 1'b0, 2'b10, 4'd3, 4'd8, 4'd12, 1'b0);

    // start pulsed in SCAN and RESULT is ignored; valid holds without ack
    sb.push_back('{kind: 2'b10, mn: 4'd2, vl: 4'd4, mx: 4'd9});
    do_start();
    snap(1'b1, 16'h03FC);
    snap(1'b0, 16'h001C);
    cap = cyc;
    wait_result(cap, 1'b1);
    for (int i = 0; i < 10; i++) begin
      start_i = (i == 4);
      tick();
      chk("hold_valid", {31'd0, valid_o}, 32'd1);
      chk("hold_value", {28'd0, value_o}, 32'd4);
    end
    start_i = 1'b0;
    ack_result();
    tick();
    chk("idle_after_ignored_start", {31'd0, busy_o}, 32'd0);
    chk("outputs_stable_after_ack", {28'd0, max_o}, 32'd9);

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
